// File: rtl/bcd_modcounter_disp_pkg.sv
// ---------------------------------------------------------------------------
// bcd_modcounter_disp_pkg
//   Shared constants, types and helpers for the BCD modulus counter/display:
//   digit and segment widths, active-low 7-segment codes for 0-9, the blank
//   pattern, the per-edge counter operation encoding and an MSD-first BCD
//   magnitude compare.
// ---------------------------------------------------------------------------
package bcd_modcounter_disp_pkg;

    localparam int         BCD_W      = 4;
    localparam int         SEG_W      = 7;
    localparam int         MAX_DIGITS = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // What the counter core does to Q on the coming clock edge.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,   // keep Q
        OP_LOAD = 3'd1,   // Q <= D
        OP_ZERO = 3'd2,   // Q <= 0 (up wrap or rejected load)
        OP_INC  = 3'd3,   // Q <= Q + 1, decimal carry
        OP_DEC  = 3'd4,   // Q <= Q - 1, decimal borrow
        OP_MAX  = 3'd5    // Q <= M - 1 (down wrap or out-of-range recovery)
    } count_op_e;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-decimal codes blank.
    function automatic logic [6:0] seg7_code(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // a < b for BCD numbers up to MAX_DIGITS digits. The most significant
    // differing digit decides, so the result is valid for well-formed BCD.
    function automatic logic bcd_lt(input logic [15:0] a, input logic [15:0] b);
        logic decided;
        logic lt;
        decided = 1'b0;
        lt      = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                decided = 1'b1;
                lt      = (a[4*i +: 4] < b[4*i +: 4]);
            end
        end
        return lt;
    endfunction

endpackage

// File: rtl/bcd_modcounter_disp_if.sv
// ---------------------------------------------------------------------------
// bcd_modcounter_disp_if
//   Control, data and display bundle of the BCD modulus counter.
//   en   count enable           up   1 = up, 0 = down
//   ld   synchronous load       d    load value, BCD, digit 0 in [3:0]
//   mod  modulus, BCD (0 or any digit > 9 selects the full 10^DIGITS range)
//   q    current count, BCD     tc   registered terminal-count pulse
//   err  sticky bad-load flag   hex  active-low segments, digit i in [7i+6:7i]
//   master: the controlling side (keys/switches, testbench)
//   slave : the counter itself
// ---------------------------------------------------------------------------
interface bcd_modcounter_disp_if
    import bcd_modcounter_disp_pkg::*;
#(
    parameter int DIGITS = 2
);
    logic                      en;
    logic                      up;
    logic                      ld;
    logic [BCD_W*DIGITS-1:0]   d;
    logic [BCD_W*DIGITS-1:0]   mod;
    logic [BCD_W*DIGITS-1:0]   q;
    logic                      tc;
    logic                      err;
    logic [SEG_W*DIGITS-1:0]   hex;

    modport master (
        output en, up, ld, d, mod,
        input  q, tc, err, hex
    );

    modport slave (
        input  en, up, ld, d, mod,
        output q, tc, err, hex
    );

endinterface

// File: rtl/bcd_seg7_dec.sv
// ---------------------------------------------------------------------------
// bcd_seg7_dec
//   One BCD digit to active-low 7-segment drive, purely combinational.
//   bcd   in  4  digit value; codes above 9 display as blank
//   blank in  1  force the digit dark (leading-zero suppression)
//   seg   out 7  active-low segments {g..a}
// ---------------------------------------------------------------------------
module bcd_seg7_dec
    import bcd_modcounter_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        seg = SEG_BLANK;
        if (!blank) begin
            seg = seg7_code(bcd);
        end
    end

endmodule

// File: rtl/bcd_modcounter_disp.sv
// ---------------------------------------------------------------------------
// bcd_modcounter_disp
//   N-digit BCD up/down counter with run-time modulus, parallel load,
//   registered terminal-count pulse, sticky load-error flag and per-digit
//   7-segment drive with optional leading-zero blanking.
//   clk  in  1  clock, rising edge (board CP)
//   rst  in  1  asynchronous active-high clear (board CLR)
//   bus  slave modport of bcd_modcounter_disp_if (en, up, ld, d, mod in;
//        q, tc, err, hex out)
//   Edge priority: rst > ld > en. hex follows q combinationally.
// ---------------------------------------------------------------------------
module bcd_modcounter_disp
    import bcd_modcounter_disp_pkg::*;
#(
    parameter int DIGITS   = 2,     // 1..4
    parameter bit BLANK_LZ = 1'b1   // blank leading-zero digits above digit 0
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_modcounter_disp_if.slave  bus
);

    localparam int W = BCD_W * DIGITS;

    logic [W-1:0]      q;
    logic [W-1:0]      mm1;          // effective modulus minus one, BCD
    logic              mod_full;     // modulus is the full 10^DIGITS range
    logic              d_valid;      // every load digit is decimal
    logic              d_in_range;   // D < M
    logic              load_ok;
    logic              q_ge_mm1;     // Q >= M-1
    logic              q_gt_mm1;     // Q >= M
    logic              q_zero;
    count_op_e         op;
    logic              wrap;
    logic              tc_r;
    logic              err_r;
    logic [DIGITS-1:0] blank;

    // -----------------------------------------------------------------------
    // Effective modulus: 0 or any non-decimal digit selects the full range.
    // -----------------------------------------------------------------------
    always_comb begin : mod_decode
        mod_full = (bus.mod == '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.mod[4*i +: 4] > BCD_MAX) begin
                mod_full = 1'b1;
            end
        end
    end

    // M-1 in BCD. A valid, non-zero modulus always absorbs the borrow, so
    // the chain needs no terminal case; the full range is simply all nines.
    always_comb begin : mm1_calc
        logic borrow;
        mm1    = '0;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (mod_full) begin
                mm1[4*i +: 4] = BCD_MAX;
            end else if (borrow) begin
                if (bus.mod[4*i +: 4] == 4'd0) begin
                    mm1[4*i +: 4] = BCD_MAX;
                end else begin
                    mm1[4*i +: 4] = bus.mod[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end else begin
                mm1[4*i +: 4] = bus.mod[4*i +: 4];
            end
        end
    end

    always_comb begin : load_check
        d_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.d[4*i +: 4] > BCD_MAX) begin
                d_valid = 1'b0;
            end
        end
    end

    // Any decimal D fits the full range; otherwise compare against MOD.
    assign d_in_range = mod_full || bcd_lt(16'(bus.d), 16'(bus.mod));
    assign load_ok    = d_valid && d_in_range;

    assign q_ge_mm1 = !bcd_lt(16'(q), 16'(mm1));
    assign q_gt_mm1 = bcd_lt(16'(mm1), 16'(q));
    assign q_zero   = (q == '0);

    // -----------------------------------------------------------------------
    // Per-edge operation. Up wraps from anything >= M-1 (including a count
    // stranded above a reduced modulus); down only wraps from zero, and a
    // stranded count drops to M-1 without a terminal-count pulse.
    // -----------------------------------------------------------------------
    always_comb begin : op_select
        op   = OP_HOLD;
        wrap = 1'b0;
        if (bus.ld) begin
            op = load_ok ? OP_LOAD : OP_ZERO;
        end else if (bus.en) begin
            if (bus.up) begin
                if (q_ge_mm1) begin
                    op   = OP_ZERO;
                    wrap = 1'b1;
                end else begin
                    op = OP_INC;
                end
            end else if (q_zero) begin
                op   = OP_MAX;
                wrap = 1'b1;
            end else if (q_gt_mm1) begin
                op = OP_MAX;
            end else begin
                op = OP_DEC;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Digit registers with ripple carry/borrow: a digit steps only when every
    // lower digit is at its rollover value (9 going up, 0 going down).
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] digit_q;
        logic [3:0] digit_d;
        logic       c_in;
        logic       b_in;

        if (i == 0) begin : g_lsd
            assign c_in = 1'b1;
            assign b_in = 1'b1;
        end else begin : g_upper
            assign c_in = g_digit[i-1].c_in && (g_digit[i-1].digit_q == BCD_MAX);
            assign b_in = g_digit[i-1].b_in && (g_digit[i-1].digit_q == 4'd0);
        end

        always_comb begin
            digit_d = digit_q;
            case (op)
                OP_LOAD: digit_d = bus.d[4*i +: 4];
                OP_ZERO: digit_d = 4'd0;
                OP_MAX:  digit_d = mm1[4*i +: 4];
                OP_INC:  if (c_in) digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
                OP_DEC:  if (b_in) digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
                default: digit_d = digit_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            if (rst) begin
                digit_q <= 4'd0;
            end else begin
                digit_q <= digit_d;
            end
        end

        assign q[4*i +: 4] = digit_q;
    end

    // Terminal count is a one-cycle pulse; err only changes on a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            tc_r <= wrap;
            if (bus.ld) begin
                err_r <= !load_ok;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Display: scan from the top digit; a digit is dark while it and every
    // digit above it are zero. Digit 0 is never blanked.
    // -----------------------------------------------------------------------
    always_comb begin : blank_gen
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (q[4*i +: 4] == 4'd0);
            blank[i]   = BLANK_LZ && zero_above;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        bcd_seg7_dec u_dec (
            .bcd   (q[4*i +: 4]),
            .blank (blank[i]),
            .seg   (bus.hex[7*i +: 7])
        );
    end

    assign bus.q   = q;
    assign bus.tc  = tc_r;
    assign bus.err = err_r;

endmodule
